// File: rtl/seven_seg_if.sv
// seven_seg_if: character feed from the message source plus display outputs.
// The master drives the characters and the slave drives the display pins.
interface seven_seg_if;
    logic [3:0] char_an0;
    logic [3:0] char_an1;
    logic [3:0] char_an2;
    logic [3:0] char_an3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    modport master (
        output char_an0, char_an1, char_an2, char_an3,
        input  an, seg, dp, frame_done
    );
    modport slave (
        input  char_an0, char_an1, char_an2, char_an3,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: scans four snapshotted hex characters onto a common-anode 7-seg display.
// Define SEVEN_SEG_DEADTIME_EN to insert an all-off BLANK period before every digit.
module seven_seg_scan_driver #(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    seven_seg_if.slave disp
);
`ifdef SEVEN_SEG_DEADTIME_EN
    typedef enum logic [1:0] {LOAD, BLANK, DRIVE} state_t;
    localparam logic [15:0] BLANK_RELOAD = 16'(BLANK_CYCLES - 1);
`else
    typedef enum logic [1:0] {LOAD, DRIVE} state_t;
`endif
    localparam logic [15:0] DIGIT_RELOAD = 16'(DIGIT_CYCLES - 1);
    // Active-low {a..g}, indexed by hex value (entry 15 listed first)
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    if (DIGIT_CYCLES < 1 || DIGIT_CYCLES > 65535 || BLANK_CYCLES < 1 || BLANK_CYCLES > 65535) begin : g_bad_param
        $error("seven_seg_scan_driver: DIGIT_CYCLES/BLANK_CYCLES must be 1..65535");
    end

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic [1:0]       r_dig, w_dig_nxt;
    logic [3:0][3:0]  r_snap, w_snap_nxt;
    logic [3:0]       r_an, w_an_nxt;
    logic [6:0]       r_seg, w_seg_nxt;
    logic             r_dp;
    logic             r_frame_done, w_frame_done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD;
            r_cnt        <= '0;
            r_dig        <= 2'd3;
            r_snap       <= '0;
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dig        <= w_dig_nxt;
            r_snap       <= w_snap_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= 1'b1;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Outputs are registered from next-state values so anode and segments switch together
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_dig_nxt        = r_dig;
        w_snap_nxt       = r_snap;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            LOAD: begin
                w_snap_nxt = {disp.char_an3, disp.char_an2, disp.char_an1, disp.char_an0};
                w_dig_nxt  = 2'd3;
`ifdef SEVEN_SEG_DEADTIME_EN
                w_state_nxt = BLANK;
                w_cnt_nxt   = BLANK_RELOAD;
`else
                w_state_nxt = DRIVE;
                w_cnt_nxt   = DIGIT_RELOAD;
`endif
            end
`ifdef SEVEN_SEG_DEADTIME_EN
            BLANK: begin
                w_state_nxt = (r_cnt == 16'd0) ? DRIVE : BLANK;
                w_cnt_nxt   = (r_cnt == 16'd0) ? DIGIT_RELOAD : r_cnt - 16'd1;
            end
`endif
            default: begin
                if (r_cnt != 16'd0) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else if (r_dig != 2'd0) begin
                    w_dig_nxt = r_dig - 2'd1;
`ifdef SEVEN_SEG_DEADTIME_EN
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = BLANK_RELOAD;
`else
                    w_cnt_nxt   = DIGIT_RELOAD;
`endif
                end else begin
                    w_state_nxt      = LOAD;
                    w_frame_done_nxt = 1'b1;
                end
            end
        endcase
        w_an_nxt  = (w_state_nxt == DRIVE) ? ~(4'b0001 << w_dig_nxt) : 4'b1111;
        w_seg_nxt = (w_state_nxt == DRIVE) ? SEG_LUT[w_snap_nxt[w_dig_nxt]] : 7'b1111111;
    end

    assign disp.an         = r_an;
    assign disp.seg        = r_seg;
    assign disp.dp         = r_dp;
    assign disp.frame_done = r_frame_done;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench; each captured frame queues its per-cycle display image,
// and a monitor compares every cycle against it.
module tb_seven_seg_scan_driver;
    localparam int D = 4;
    localparam int B = 2;
`ifdef SEVEN_SEG_DEADTIME_EN
    localparam int BL = B;
`else
    localparam int BL = 0;
`endif
    localparam int F = 1 + 4 * (BL + D);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] chars [4];
    bit         mon_en = 1'b0;
    exp_t       q [$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_seg_if disp ();
    assign disp.char_an0 = chars[0];
    assign disp.char_an1 = chars[1];
    assign disp.char_an2 = chars[2];
    assign disp.char_an3 = chars[3];

    seven_seg_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Expected display image of one frame, built from the characters seen at capture
    task automatic push_frame();
        logic [3:0] s [4];
        exp_t e;
        for (int i = 0; i < 4; i++) s[i] = chars[i];
        for (int d = 3; d >= 0; d--) begin
            for (int k = 0; k < BL; k++) q.push_back('{4'b1111, 7'b1111111, 1'b0});
            e.an = 4'b1111;
            e.an[d] = 1'b0;
            e.seg = tbl[s[d]];
            e.fd = 1'b0;
            for (int k = 0; k < D; k++) q.push_back(e);
        end
        q.push_back('{4'b1111, 7'b1111111, 1'b1});
    endtask

    task automatic run_frame(input bit perturb, input bit force_a);
        push_frame();
        for (int c = 0; c < F; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < F - 1) begin
                if (force_a) chars[0] = 4'hA;
                else if (perturb) chars[$urandom_range(3)] = 4'($urandom);
            end
        end
    endtask

    task automatic rand_chars();
        for (int i = 0; i < 4; i++) chars[i] = 4'($urandom);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                a = '{disp.an, disp.seg, disp.frame_done};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scan: got an=%b seg=%b fd=%b with nothing expected", a.an, a.seg, a.fd);
                end else begin
                    e = q.pop_front();
                    if (a !== e || disp.dp !== 1'b1) begin
                        errors++;
                        $display("FAIL scan: got an=%b seg=%b fd=%b dp=%b, want an=%b seg=%b fd=%b dp=1",
                                 a.an, a.seg, a.fd, disp.dp, e.an, e.seg, e.fd);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) chars[i] = 4'd0;
        #1 reset = 1'b1;
        #1;
        chk("reset_an", 32'(disp.an), 32'hF);
        chk("reset_seg", 32'(disp.seg), 32'h7F);
        chk("reset_dp", 32'(disp.dp), 32'h1);
        chk("reset_fd", 32'(disp.frame_done), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chars[3] = 4'd1;
        chars[2] = 4'd2;
        chars[1] = 4'd3;
        chars[0] = 4'd4;
        mon_en = 1'b1;
        run_frame(1'b0, 1'b0);
        for (int v = 0; v < 16; v++) begin
            rand_chars();
            chars[3] = 4'(v);
            run_frame(1'b1, 1'b0);
        end
        rand_chars();
        chars[0] = 4'h5;
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b0);
        repeat (6) begin
            rand_chars();
            run_frame(1'b1, 1'b0);
        end
        mon_en = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'h0);
        q.delete();
        rand_chars();
        repeat (BL + 2) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_an", 32'(disp.an), 32'h7);
        chk("pre_reset_seg", 32'(disp.seg), 32'(tbl[chars[3]]));
        #2 reset = 1'b1;
        #1;
        chk("midframe_reset_an", 32'(disp.an), 32'hF);
        chk("midframe_reset_seg", 32'(disp.seg), 32'h7F);
        chk("midframe_reset_fd", 32'(disp.frame_done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rand_chars();
        mon_en = 1'b1;
        run_frame(1'b1, 1'b0);
        rand_chars();
        run_frame(1'b1, 1'b0);
        mon_en = 1'b0;
        chk("queue_drained_end", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
